calc_entry_fsm: RTL and testbench
=================================

# calc_entry_fsm

Operand-entry and arithmetic sequencer for the calculator. It sits directly downstream of the per-button filter stages and consumes their single-cycle pulses (enter, operator-cycle, clear), together with the switch-bank operand value. It collects two operands and an operator, then computes the result: single-cycle for add, subtract and AND, or an iterative shift-add for multiply. The result is held for the display stage.

## Interface
- `WIDTH`, default 8: operand width in bits; the result is `2*WIDTH` bits.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `operand`  input  WIDTH: operand value from the switches, sampled only on an accepted enter.
- `enter_p`  input  1: single-cycle enter pulse from the button filter.
- `op_p`  input  1: single-cycle operator-cycle pulse.
- `clear_p`  input  1: single-cycle clear pulse.
- `result`  output  2*WIDTH: held result magnitude.
- `neg`  output  1: result is negative (subtract only).
- `op_sel`  output  2: current operator (0 ADD, 1 SUB, 2 MUL, 3 AND).
- `state`  output  2: FSM state encoding.
- `busy`  output  1: multiply in progress.
- `done`  output  1: one-cycle pulse when a result becomes valid.

## Operation
- States and encodings: GET_A=0, GET_B=1, BUSY=2, SHOW=3.
- Reset values: state=GET_A; result, neg, op_sel, busy and done all 0; internal A, B, accumulator and counter all 0.
- Input priority, same cycle: clear_p > enter_p > op_p. Lower-priority pulses in that cycle are dropped.
- clear_p in any state (including BUSY):
  - next state GET_A;
  - result, neg, op_sel, A, B, counter and accumulator go to 0;
  - no done pulse.
- GET_A:
  - enter_p: A <= operand, go to GET_B.
  - op_p: op_sel <= op_sel+1 (mod 4, wraps 3→0).
- GET_B:
  - op_p behaves as in GET_A.
  - enter_p: B <= operand.
  - If op_sel=MUL: go to BUSY, accumulator <= 0, counter <= 0.
  - Otherwise: compute and go to SHOW.
- ADD: result = A+B, zero-extended. The carry lands in bit WIDTH.
- SUB:
  - If A>=B: result = A-B, neg=0.
  - If A<B: result = B-A, neg=1. A=B gives 0 with neg=0.
- AND: result = {WIDTH'b0, A&B}, neg=0.
- MUL: unsigned shift-add, one multiplier bit per cycle, LSB first, over WIDTH cycles.
  - Accumulator is 2*WIDTH bits.
  - On the final iteration: result <= accumulator, neg=0.
  - result keeps its previous value until then.
- BUSY:
  - busy=1.
  - enter_p and op_p are ignored; only clear_p aborts.
- SHOW:
  - done=1 on the first cycle only.
  - result, neg and op_sel are held.
  - op_p is ignored.
  - enter_p: go to GET_A. A, B and result are unchanged until reloaded; op_sel is kept.

## Timing
- Add, subtract or AND, with enter_p accepted in GET_B at edge n: result valid and done=1 in cycle n+1.
- Multiply, with enter_p accepted in GET_B at edge n:
  - busy=1 for cycles n+1 through n+WIDTH;
  - state=SHOW, result valid and done=1 in cycle n+WIDTH+1;
  - busy=0 in that same cycle.
- done is exactly one cycle wide and never asserts twice for one computation.
- Output latency from a state change to `state`: 0 cycles (registered state driven directly).
- Asynchronous rst mid-multiply:
  - all outputs go to their reset values immediately;
  - no done pulse follows after rst deasserts.
- Inputs are assumed to be single-cycle pulses. A level held high is treated as one pulse per cycle it is high; no edge detection is done here.

## Configuration
- `CALC_CHAIN_EN` defined: enter_p in SHOW loads A <= result[WIDTH-1:0] and goes to GET_B. This allows chained operations such as 3+4, then ×2.
- `CALC_CHAIN_EN` defined, upper half non-zero: if result[2*WIDTH-1:WIDTH] is non-zero, chaining is refused and the FSM goes to GET_A as in the default build.
- `CALC_CHAIN_EN` undefined: enter_p in SHOW goes to GET_A with no load.

## Test plan
- Add, WIDTH=8: reset; enter 200; enter 100 with op=ADD → one cycle later result=300 (0x012C), neg=0, done high for exactly 1 cycle.
- Subtract: op_p once (op_sel=1); enter 5; enter 9 → result=4, neg=1. Then enter 9 as A and 9 as B → result=0, neg=0.
- Multiply: op_p twice (op_sel=2); enter 255; enter 255 → busy high for 8 cycles, then result=65025 (0xFE01) with done, state=SHOW.
- Clear and reset during multiply: clear_p pulsed mid-multiply → state=GET_A, result=0, op_sel=0, no done. Separately, rst asserted at cycle 4 of a multiply → the same reset values immediately.
- Priority and wrap: enter_p and op_p in the same cycle in GET_A → A loaded, op_sel unchanged. Four op_p pulses → op_sel returns to 0. op_p during BUSY is ignored.
- `CALC_CHAIN_EN` build:
  - 3+4=7; enter; ADD with 2 → result=9;
  - 16×16=256; enter → state=GET_A (chain refused).

Source files
------------

// File: rtl/calc_entry_fsm_if.sv
// Handshake bundle between the button/switch front end and calc_entry_fsm.
// The master drives the pulses and operand. The slave returns the result and status.
interface calc_entry_fsm_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0]   operand;
  logic               enter_p;
  logic               op_p;
  logic               clear_p;
  logic [2*WIDTH-1:0] result;
  logic               neg;
  logic [1:0]         op_sel;
  logic [1:0]         state;
  logic               busy;
  logic               done;

  modport master (
    output operand, enter_p, op_p, clear_p,
    input  result, neg, op_sel, state, busy, done
  );

  modport slave (
    input  operand, enter_p, op_p, clear_p,
    output result, neg, op_sel, state, busy, done
  );
endinterface

// File: rtl/calc_entry_fsm.sv
// Calculator operand-entry sequencer: collects A, B and an operator, then computes ADD/SUB/AND in one cycle or MUL by shift-add.
// Define CALC_CHAIN_EN so that enter in SHOW reloads A from the result, which chains operations.
module calc_entry_fsm #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  calc_entry_fsm_if.slave  bus
);
  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    BUSY  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [RW-1:0]     r_acc;
  logic [RW-1:0]     r_result;
  logic              r_neg;
  logic [1:0]        r_op_sel;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;

  logic [RW-1:0]     w_partial;
  logic [RW-1:0]     w_acc_next;
  logic [RW-1:0]     w_alu_res;
  logic              w_alu_neg;

  // One shift-add step: add A shifted by the current multiplier bit position
  always_comb begin
    w_partial  = '0;
    if (r_b[r_cnt]) begin
      w_partial = RW'(r_a) << r_cnt;
    end
    w_acc_next = r_acc + w_partial;
  end

  // Single-cycle ops use the operand directly, because B is loaded on this same edge
  always_comb begin
    w_alu_res = '0;
    w_alu_neg = 1'b0;
    case (r_op_sel)
      OP_ADD: w_alu_res = RW'(r_a) + RW'(bus.operand);
      OP_SUB: begin
        if (r_a >= bus.operand) begin
          w_alu_res = RW'(r_a - bus.operand);
        end else begin
          w_alu_res = RW'(bus.operand - r_a);
          w_alu_neg = 1'b1;
        end
      end
      OP_AND: w_alu_res = RW'(r_a & bus.operand);
      default: w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= GET_A;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_op_sel <= 2'd0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.clear_p) begin
        r_state  <= GET_A;
        r_a      <= '0;
        r_b      <= '0;
        r_acc    <= '0;
        r_result <= '0;
        r_neg    <= 1'b0;
        r_op_sel <= 2'd0;
        r_cnt    <= '0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          GET_A: begin
            if (bus.enter_p) begin
              r_a     <= bus.operand;
              r_state <= GET_B;
            end else if (bus.op_p) begin
              r_op_sel <= r_op_sel + 2'd1;
            end
          end
          GET_B: begin
            if (bus.enter_p) begin
              r_b <= bus.operand;
              if (r_op_sel == OP_MUL) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= BUSY;
              end else begin
                r_result <= w_alu_res;
                r_neg    <= w_alu_neg;
                r_done   <= 1'b1;
                r_state  <= SHOW;
              end
            end else if (bus.op_p) begin
              r_op_sel <= r_op_sel + 2'd1;
            end
          end
          BUSY: begin
            r_acc <= w_acc_next;
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_result <= w_acc_next;
              r_neg    <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= SHOW;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          SHOW: begin
            if (bus.enter_p) begin
`ifdef CALC_CHAIN_EN
              // Chaining only when the result still fits in one operand
              if (r_result[RW-1:WIDTH] == '0) begin
                r_a     <= r_result[WIDTH-1:0];
                r_state <= GET_B;
              end else begin
                r_state <= GET_A;
              end
`else
              r_state <= GET_A;
`endif
            end
          end
          default: r_state <= GET_A;
        endcase
      end
    end
  end

  assign bus.result = r_result;
  assign bus.neg    = r_neg;
  assign bus.op_sel = r_op_sel;
  assign bus.state  = r_state;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
endmodule

// File: tb/tb_calc_entry_fsm.sv
// Self-checking bench for calc_entry_fsm (WIDTH=8): a cycle-level reference model is compared against the DUT every cycle,
// and directed literal checks pin the model itself.
module tb_calc_entry_fsm;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  calc_entry_fsm_if #(.WIDTH(W)) bus ();

  calc_entry_fsm #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_state = 0;
  int m_a = 0, m_b = 0, m_res = 0, m_neg = 0, m_op = 0;
  int m_busy = 0, m_done = 0, m_left = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_neg = 0;
        m_op = 0; m_busy = 0; m_done = 0; m_left = 0;
      end else begin
        m_done = 0;
        if (bus.clear_p) begin
          m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_neg = 0;
          m_op = 0; m_busy = 0; m_left = 0;
        end else begin
          case (m_state)
            0: if (bus.enter_p) begin
                 m_a = int'(bus.operand); m_state = 1;
               end else if (bus.op_p) m_op = (m_op + 1) % 4;
            1: if (bus.enter_p) begin
                 m_b = int'(bus.operand);
                 if (m_op == 2) begin
                   m_state = 2; m_busy = 1; m_left = W;
                 end else begin
                   case (m_op)
                     0: begin m_res = m_a + m_b; m_neg = 0; end
                     1: begin
                          if (m_a >= m_b) begin m_res = m_a - m_b; m_neg = 0; end
                          else begin m_res = m_b - m_a; m_neg = 1; end
                        end
                     default: begin m_res = m_a & m_b; m_neg = 0; end
                   endcase
                   m_state = 3; m_done = 1;
                 end
               end else if (bus.op_p) m_op = (m_op + 1) % 4;
            2: begin
                 m_left--;
                 if (m_left == 0) begin
                   m_res = m_a * m_b; m_neg = 0; m_busy = 0; m_done = 1; m_state = 3;
                 end
               end
            default: if (bus.enter_p) begin
`ifdef CALC_CHAIN_EN
                 if (m_res < (1 << W)) begin m_a = m_res; m_state = 1; end
                 else m_state = 0;
`else
                 m_state = 0;
`endif
               end
          endcase
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("result", int'(bus.result), m_res);
      check("neg",    int'(bus.neg),    m_neg);
      check("op_sel", int'(bus.op_sel), m_op);
      check("state",  int'(bus.state),  m_state);
      check("busy",   int'(bus.busy),   m_busy);
      check("done",   int'(bus.done),   m_done);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press_enter(input logic [W-1:0] v);
    bus.operand = v; bus.enter_p = 1'b1; tick(); bus.enter_p = 1'b0;
  endtask

  task automatic press_op();
    bus.op_p = 1'b1; tick(); bus.op_p = 1'b0;
  endtask

  task automatic press_clear();
    bus.clear_p = 1'b1; tick(); bus.clear_p = 1'b0;
  endtask

  // Wait for done while counting busy cycles; inject ignored op/enter pulses mid-multiply
  task automatic run_mul(input int budget, output int busy_cycles, output bit got);
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (bus.done) got = 1'b1;
      else begin
        if (bus.busy) busy_cycles++;
        bus.op_p    = (i == 2);
        bus.enter_p = (i == 4);
        bus.operand = 8'd7;
        tick();
      end
    end
    bus.op_p = 1'b0;
    bus.enter_p = 1'b0;
  endtask

  initial begin
    int bc;
    bit got;
    bus.operand = '0; bus.enter_p = 1'b0; bus.op_p = 1'b0; bus.clear_p = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state",  int'(bus.state),  0);
    check("rst_result", int'(bus.result), 0);
    check("rst_op_sel", int'(bus.op_sel), 0);
    check("rst_done",   int'(bus.done),   0);
    @(negedge clk);
    rst = 1'b0;

    // ADD 200 + 100 = 300 with carry into bit 8
    press_enter(8'd200);
    press_enter(8'd100);
    check("add_result", int'(bus.result), 300);
    check("add_neg",    int'(bus.neg),    0);
    check("add_done",   int'(bus.done),   1);
    tick();
    check("add_done_1cyc", int'(bus.done), 0);
    press_enter(8'd0);
    check("show_exit_big", int'(bus.state), 0);

    // SUB 5 - 9 -> 4 negative; 9 - 9 -> 0 non-negative
    press_op();
    press_enter(8'd5);
    press_enter(8'd9);
    check("sub_result", int'(bus.result), 4);
    check("sub_neg",    int'(bus.neg),    1);
    press_clear();
    check("clr_op_sel", int'(bus.op_sel), 0);
    press_op();
    press_enter(8'd9);
    press_enter(8'd9);
    check("sub_eq_result", int'(bus.result), 0);
    check("sub_eq_neg",    int'(bus.neg),    0);
    press_clear();

    // AND
    press_op(); press_op(); press_op();
    press_enter(8'hF0);
    press_enter(8'h3C);
    check("and_result", int'(bus.result), 'h30);
    press_clear();

    // Priority enter > op, then op_sel wrap in GET_B
    bus.operand = 8'd42; bus.enter_p = 1'b1; bus.op_p = 1'b1; tick();
    bus.enter_p = 1'b0; bus.op_p = 1'b0;
    check("prio_state",  int'(bus.state),  1);
    check("prio_op_sel", int'(bus.op_sel), 0);
    press_op(); press_op();
    check("op_sel_2", int'(bus.op_sel), 2);
    press_op(); press_op();
    check("op_sel_wrap", int'(bus.op_sel), 0);
    press_clear();

    // MUL 255 * 255 with ignored pulses during BUSY
    press_op(); press_op();
    press_enter(8'd255);
    press_enter(8'd255);
    run_mul(30, bc, got);
    check("mul_done_seen", int'(got), 1);
    check("mul_busy_cycles", bc, 8);
    check("mul_result", int'(bus.result), 'hFE01);
    check("mul_state", int'(bus.state), 3);
    check("mul_op_sel", int'(bus.op_sel), 2);
    tick();
    check("mul_done_1cyc", int'(bus.done), 0);

    // Clear mid-multiply
    press_clear();
    press_op(); press_op();
    press_enter(8'd13);
    press_enter(8'd11);
    repeat (3) tick();
    press_clear();
    check("clr_mul_state",  int'(bus.state),  0);
    check("clr_mul_result", int'(bus.result), 0);
    check("clr_mul_op_sel", int'(bus.op_sel), 0);
    check("clr_mul_done",   int'(bus.done),   0);
    repeat (10) tick();

    // Async reset mid-multiply
    press_op(); press_op();
    press_enter(8'd200);
    press_enter(8'd3);
    repeat (3) tick();
    check("pre_rst_busy", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_state",  int'(bus.state),  0);
    check("arst_busy",   int'(bus.busy),   0);
    check("arst_op_sel", int'(bus.op_sel), 0);
    check("arst_result", int'(bus.result), 0);
    tick();
    rst = 1'b0;
    repeat (12) tick();

    // Enter in SHOW after a small result
    press_enter(8'd3);
    press_enter(8'd4);
    check("add7", int'(bus.result), 7);
    press_enter(8'd0);
`ifdef CALC_CHAIN_EN
    check("chain_state", int'(bus.state), 1);
    press_enter(8'd2);
    check("chain_result", int'(bus.result), 9);
    press_clear();
    press_op(); press_op();
    press_enter(8'd16);
    press_enter(8'd16);
    run_mul(30, bc, got);
    check("chain_mul_result", int'(bus.result), 256);
    press_enter(8'd0);
    check("chain_refused", int'(bus.state), 0);
`else
    check("nochain_state", int'(bus.state), 0);
`endif
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
